// File: rtl/div_iter_param_pkg.sv
// div_iter_param_pkg: shared state codes, handshake levels and latched-mode type for the iterative divider
package div_iter_param_pkg;
    localparam logic [1:0] DIV_FREE = 2'd0;
    localparam logic [1:0] DIV_ON   = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_END  = 2'd3;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
    } div_mode_t;
endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step on unsigned magnitudes
module div_iter_step
    import div_iter_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quo_o
);
    logic [WIDTH:0] shifted;
    assign shifted = {rem_i, bit_i};
    assign quo_o   = shifted >= {1'b0, divisor_i};
    // a successful subtraction always leaves a value below the divisor, so WIDTH bits suffice
    assign rem_o   = WIDTH'(quo_o ? shifted - {1'b0, divisor_i} : shifted);
endmodule

// File: rtl/div_iter_param.sv
// div_iter_param: iterative restoring divider, BITS_PER_CYCLE quotient bits per clock,
// signed/unsigned with latched operands, divide-by-zero flag and annul support
module div_iter_param
    import div_iter_param_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    div_mode_t          mode_q, mode_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d, dz_q, dz_d;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   rem_c [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0]   quo_c [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] qb;

    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? ~opdata1_i + WIDTH'(1) : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? ~opdata2_i + WIDTH'(1) : opdata2_i;

    // quo_q starts as the dividend magnitude; its MSBs feed the steps while quotient bits shift in
    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_iter_step #(.WIDTH(WIDTH)) u_step (
            .rem_i    (rem_c[g]),
            .divisor_i(dvs_q),
            .bit_i    (quo_c[g][WIDTH-1]),
            .rem_o    (rem_c[g+1]),
            .quo_o    (qb[g])
        );
        assign quo_c[g+1] = {quo_c[g][WIDTH-2:0], qb[g]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        mode_d   = mode_q;
        result_d = result_q;
        ready_d  = ready_q;
        dz_d     = dz_q;
        case (state_q)
            DIV_FREE: if (start_i == DIV_START && !annul_i) begin
                mode_d.neg_quo = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                mode_d.neg_rem = signed_div_i & opdata1_i[WIDTH-1];
                dvs_d = mag2;
                quo_d = mag1;
                rem_d = '0;
                cnt_d = '0;
                if (opdata2_i == '0) begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                    dz_d     = 1'b1;
                end else begin
                    state_d = DIV_ON;
                end
            end
            DIV_ON: if (annul_i) begin
                state_d = DIV_FREE;
            end else begin
                rem_d   = rem_c[BITS_PER_CYCLE];
                quo_d   = quo_c[BITS_PER_CYCLE];
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == LAST) ? DIV_FIX : DIV_ON;
            end
            DIV_FIX: if (annul_i) begin
                state_d = DIV_FREE;
            end else begin
                result_d = {mode_q.neg_rem ? ~rem_q + WIDTH'(1) : rem_q,
                            mode_q.neg_quo ? ~quo_q + WIDTH'(1) : quo_q};
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            DIV_END: if (start_i == DIV_STOP) begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                dz_d     = 1'b0;
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            mode_q   <= '0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            dz_q     <= dz_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign busy_o     = (state_q == DIV_ON) || (state_q == DIV_FIX);
    assign div_zero_o = dz_q;
endmodule
